// File: rtl/des_56_sequencer.sv
// Issue/collect sequencer in front of the des_56 round pipeline.
// One block in flight; key/state copies are wiped once the core has them.
module des_56_sequencer #(
    parameter int TIMEOUT = 24,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [55:0] in_state,
    input  logic [55:0] in_key,
    output logic        core_start,
    output logic [55:0] core_state,
    output logic [55:0] core_key,
    input  logic [55:0] core_out,
    input  logic        core_out_valid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [55:0] res_data,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] W_TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] W_ONE = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start;
    logic              w_start_nxt;
    logic [55:0]       r_cstate;
    logic [55:0]       w_cstate_nxt;
    logic [55:0]       r_ckey;
    logic [55:0]       w_ckey_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_res_valid;
    logic              w_res_valid_nxt;
    logic [55:0]       r_res_data;
    logic [55:0]       w_res_data_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_cstate    <= '0;
            r_ckey      <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start     <= w_start_nxt;
            r_cstate    <= w_cstate_nxt;
            r_ckey      <= w_ckey_nxt;
            r_cnt       <= w_cnt_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start_nxt     = 1'b0;
        w_cstate_nxt    = r_cstate;
        w_ckey_nxt      = r_ckey;
        w_cnt_nxt       = r_cnt;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_timeout_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_cstate_nxt = in_state;
                    w_ckey_nxt   = in_key;
                    w_state_nxt  = S_ARM;
                end
            end
            S_ARM: begin
                // start was low this cycle, so the next one is a clean rise
                w_start_nxt = 1'b1;
                w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_cstate_nxt = '0;
                w_ckey_nxt   = '0;
                w_cnt_nxt    = W_ONE;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // a result arriving on the last allowed cycle beats the timeout
                if (core_out_valid) begin
                    w_res_data_nxt  = core_out;
                    w_res_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_DONE;
                end else if (r_cnt >= W_TMO) begin
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + W_ONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_res_data_nxt  = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout;
    assign core_start  = r_start;
    assign core_state  = r_cstate;
    assign core_key    = r_ckey;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;

endmodule

// File: tb/tb_des_56_sequencer.sv
// Directed bench for des_56_sequencer: vector table plus hand-written
// timeout, stale-valid, coincidence and mid-operation reset sequences.
module tb_des_56_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] in_state;
    logic [55:0] in_key;
    logic        core_start;
    logic [55:0] core_state;
    logic [55:0] core_key;
    logic [55:0] core_out;
    logic        core_out_valid;
    logic        res_valid;
    logic        res_ready;
    logic [55:0] res_data;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    localparam logic [55:0] S1 = 56'h0123456789ABCD;
    localparam logic [55:0] K1 = 56'hA5A5A5A5A5A5A5;
    localparam logic [55:0] R1 = 56'h00FEDCBA987654;
    localparam logic [55:0] S2 = 56'h13579BDF02468A;
    localparam logic [55:0] K2 = 56'h0F0F0F0F0F0F0F;
    localparam logic [55:0] S3 = 56'hFFFFFFFFFFFFFF;
    localparam logic [55:0] K3 = 56'h3C3C3C3C3C3C3C;
    localparam logic [55:0] R2 = 56'h5A5A5A5A5A5A5A;
    localparam logic [55:0] R3 = 56'h0000000000C0DE;
    localparam logic [55:0] R4 = 56'h00BEEF00BEEF00;
    localparam logic [55:0] R5 = 56'h77665544332211;
    localparam logic [55:0] X1 = 56'h11111111111111;
    localparam logic [55:0] X2 = 56'h22222222222222;
    localparam logic [55:0] Z  = 56'd0;

    typedef struct {
        int          n;
        logic        iv;
        logic [55:0] is;
        logic [55:0] ik;
        logic        cov;
        logic [55:0] co;
        logic        rr;
        logic        e_ir;
        logic        e_st;
        logic [55:0] e_cs;
        logic [55:0] e_ck;
        logic        e_rv;
        logic [55:0] e_rd;
        logic        e_busy;
        logic        e_to;
    } vec_t;

    vec_t tbl [16];

    des_56_sequencer #(
        .TIMEOUT(24),
        .CNT_W  (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_state      (in_state),
        .in_key        (in_key),
        .core_start    (core_start),
        .core_state    (core_state),
        .core_key      (core_key),
        .core_out      (core_out),
        .core_out_valid(core_out_valid),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [55:0] act,
                       input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic e_ir,
                           input logic e_st, input logic [55:0] e_cs,
                           input logic [55:0] e_ck, input logic e_rv,
                           input logic [55:0] e_rd, input logic e_busy,
                           input logic e_to);
        chkb({t, ".in_ready"}, in_ready, e_ir);
        chkb({t, ".core_start"}, core_start, e_st);
        chk({t, ".core_state"}, core_state, e_cs);
        chk({t, ".core_key"}, core_key, e_ck);
        chkb({t, ".res_valid"}, res_valid, e_rv);
        chk({t, ".res_data"}, res_data, e_rd);
        chkb({t, ".busy"}, busy, e_busy);
        chkb({t, ".timeout_err"}, timeout_err, e_to);
    endtask

    task automatic chk_reset(input string t);
        chk_all(t, 1'b1, 1'b0, Z, Z, 1'b0, Z, 1'b0, 1'b0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                in_valid       = tbl[i].iv;
                in_state       = tbl[i].is;
                in_key         = tbl[i].ik;
                core_out_valid = tbl[i].cov;
                core_out       = tbl[i].co;
                res_ready      = tbl[i].rr;
                tick();
                chk_all($sformatf("row%0d.%0d", i, k), tbl[i].e_ir,
                        tbl[i].e_st, tbl[i].e_cs, tbl[i].e_ck, tbl[i].e_rv,
                        tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_to);
            end
        end
        in_valid       = 1'b0;
        core_out_valid = 1'b0;
        res_ready      = 1'b1;
    endtask

    // Accept a block and advance to the first WAIT cycle (counter = 1).
    task automatic start_op(input logic [55:0] s, input logic [55:0] k);
        in_valid = 1'b1;
        in_state = s;
        in_key   = k;
        tick();
        in_valid = 1'b0;
        tick();
        chkb("op.fire_start", core_start, 1'b1);
        tick();
    endtask

    initial begin
        // basic + back-pressure
        tbl[0]  = '{1,  1'b1, S1, K1, 1'b0, Z,  1'b1,
                    1'b0, 1'b0, S1, K1, 1'b0, Z,  1'b1, 1'b0};
        tbl[1]  = '{1,  1'b0, S3, K3, 1'b0, Z,  1'b1,
                    1'b0, 1'b1, S1, K1, 1'b0, Z,  1'b1, 1'b0};
        tbl[2]  = '{1,  1'b0, S3, K3, 1'b0, Z,  1'b1,
                    1'b0, 1'b0, Z,  Z,  1'b0, Z,  1'b1, 1'b0};
        tbl[3]  = '{15, 1'b0, S3, K3, 1'b0, X1, 1'b1,
                    1'b0, 1'b0, Z,  Z,  1'b0, Z,  1'b1, 1'b0};
        tbl[4]  = '{1,  1'b0, S3, K3, 1'b1, R1, 1'b0,
                    1'b0, 1'b0, Z,  Z,  1'b1, R1, 1'b1, 1'b0};
        tbl[5]  = '{5,  1'b0, S3, K3, 1'b1, X1, 1'b0,
                    1'b0, 1'b0, Z,  Z,  1'b1, R1, 1'b1, 1'b0};
        tbl[6]  = '{5,  1'b0, S3, K3, 1'b0, X2, 1'b0,
                    1'b0, 1'b0, Z,  Z,  1'b1, R1, 1'b1, 1'b0};
        tbl[7]  = '{1,  1'b0, S3, K3, 1'b0, X2, 1'b1,
                    1'b1, 1'b0, Z,  Z,  1'b0, Z,  1'b0, 1'b0};
        // busy intake: new data offered in ARM, WAIT, DONE
        tbl[8]  = '{1,  1'b1, S2, K2, 1'b0, Z,  1'b1,
                    1'b0, 1'b0, S2, K2, 1'b0, Z,  1'b1, 1'b0};
        tbl[9]  = '{1,  1'b1, S3, K3, 1'b0, Z,  1'b1,
                    1'b0, 1'b1, S2, K2, 1'b0, Z,  1'b1, 1'b0};
        tbl[10] = '{1,  1'b0, S3, K3, 1'b0, Z,  1'b1,
                    1'b0, 1'b0, Z,  Z,  1'b0, Z,  1'b1, 1'b0};
        tbl[11] = '{15, 1'b1, S3, K3, 1'b0, Z,  1'b1,
                    1'b0, 1'b0, Z,  Z,  1'b0, Z,  1'b1, 1'b0};
        tbl[12] = '{1,  1'b1, S3, K3, 1'b1, R2, 1'b0,
                    1'b0, 1'b0, Z,  Z,  1'b1, R2, 1'b1, 1'b0};
        tbl[13] = '{3,  1'b1, S3, K3, 1'b0, X1, 1'b0,
                    1'b0, 1'b0, Z,  Z,  1'b1, R2, 1'b1, 1'b0};
        tbl[14] = '{1,  1'b1, S3, K3, 1'b0, X1, 1'b1,
                    1'b1, 1'b0, Z,  Z,  1'b0, Z,  1'b0, 1'b0};
        tbl[15] = '{1,  1'b0, S3, K3, 1'b0, X1, 1'b1,
                    1'b1, 1'b0, Z,  Z,  1'b0, Z,  1'b0, 1'b0};

        rst            = 1'b1;
        in_valid       = 1'b0;
        in_state       = Z;
        in_key         = Z;
        core_out       = Z;
        core_out_valid = 1'b0;
        res_ready      = 1'b1;
        tick();
        tick();
        chk_reset("rst.hold");
        rst = 1'b0;
        tick();
        chk_reset("rst.idle");

        run_rows(0, 15);

        // timeout: core never answers
        start_op(S1, K1);
        for (int k = 1; k <= 24; k++) begin
            chkb($sformatf("tmo.err.c%0d", k), timeout_err, 1'b0);
            chk($sformatf("tmo.key.c%0d", k), core_key, Z);
            chkb($sformatf("tmo.rv.c%0d", k), res_valid, 1'b0);
            chkb($sformatf("tmo.busy.c%0d", k), busy, 1'b1);
            tick();
        end
        chk_all("tmo.pulse", 1'b1, 1'b0, Z, Z, 1'b0, Z, 1'b0, 1'b1);
        tick();
        chk_reset("tmo.after");

        // result on the last allowed cycle wins over the timeout
        start_op(S2, K2);
        for (int k = 1; k < 24; k++) tick();
        core_out_valid = 1'b1;
        core_out       = R5;
        res_ready      = 1'b0;
        tick();
        chk_all("coin.done", 1'b0, 1'b0, Z, Z, 1'b1, R5, 1'b1, 1'b0);
        core_out_valid = 1'b0;
        res_ready      = 1'b1;
        tick();
        chk_reset("coin.idle");
        tick();
        chk_reset("coin.idle2");

        // stale valid level carried into the next operation
        start_op(S1, K1);
        for (int k = 0; k < 15; k++) tick();
        core_out_valid = 1'b1;
        core_out       = R3;
        tick();
        chk_all("stale.res1", 1'b0, 1'b0, Z, Z, 1'b1, R3, 1'b1, 1'b0);
        tick();
        chk_reset("stale.idle");
        in_valid = 1'b1;
        in_state = S2;
        in_key   = K2;
        tick();
        in_valid = 1'b0;
        chk_all("stale.arm", 1'b0, 1'b0, S2, K2, 1'b0, Z, 1'b1, 1'b0);
        tick();
        chk_all("stale.fire", 1'b0, 1'b1, S2, K2, 1'b0, Z, 1'b1, 1'b0);
        tick();
        chk_all("stale.w1", 1'b0, 1'b0, Z, Z, 1'b0, Z, 1'b1, 1'b0);
        core_out_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chkb($sformatf("stale.rv.%0d", k), res_valid, 1'b0);
        end
        core_out_valid = 1'b1;
        core_out       = R4;
        tick();
        chk_all("stale.res2", 1'b0, 1'b0, Z, Z, 1'b1, R4, 1'b1, 1'b0);
        core_out_valid = 1'b0;
        tick();
        chk_reset("stale.idle2");

        // reset in the middle of WAIT, then a normal operation
        start_op(S2, K2);
        for (int k = 1; k < 8; k++) tick();
        chkb("mrst.busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_reset("mrst.reset");
        rst = 1'b0;
        tick();
        chk_reset("mrst.idle");
        run_rows(0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
